wave_gen: RTL and testbench
===========================

// Module: wave_gen
// PURPOSE
//  Digital waveform source: produces an unsigned WIDTH-bit sample stream (sawtooth, triangle or square).
//  A one-cycle command strobe selects the waveform and restarts it from phase 0.
//  The output feeds a DAC or PWM stage.
//  One sample step per enabled prescaler tick.
// PARAMETERS
//  WIDTH  8  sample width; MAX = 2**WIDTH-1
//  DIV    1  clock cycles per waveform step (>=1); DIV=1 steps every enabled cycle
// PORTS
//  clk        in   1      system clock; all state updates on its rising edge
//  rst        in   1      asynchronous, active-high reset
//  en         in   1      step enable; low = freeze waveform (hold output)
//  cmd_rdy    in   1      command strobe; samples wave_type on this edge
//  wave_type  in   8      waveform code: 1=SAWTOOTH, 2=TRIANGLE, 3=SQUARE, other=IDLE
//  wave_out   out  WIDTH  current sample, unsigned
// BEHAVIOUR
//  State registers:
//   - mode[1:0] (IDLE=0, SAW=1, TRI=2, SQR=3)
//   - phase[WIDTH-1:0]
//   - dir (0=up, 1=down)
//   - div_cnt
//  Reset: mode=IDLE, phase=0, dir=up, div_cnt=0; wave_out=0 while rst is high and after release.
//  Priority per edge: rst > cmd_rdy > step.
//  cmd_rdy=1 at an edge:
//   - mode<=wave_type[1:0] if wave_type is 1..3, else IDLE (upper bits must be 0)
//   - phase<=0, dir<=up, div_cnt<=0
//   - loads regardless of en; a new command mid-waveform restarts from phase 0
//  Tick: en=1 and div_cnt==DIV-1, then div_cnt<=0; otherwise div_cnt increments while en=1.
//   - en=0 holds div_cnt and all state
//  Step on tick, by mode:
//   - IDLE: nothing changes
//   - SAW: phase<=phase+1, wrapping MAX->0 (period 2**WIDTH steps)
//   - TRI, dir=up: phase+1; at phase==MAX, phase<=MAX-1 and dir<=down
//   - TRI, dir=down: phase-1; at phase==0, phase<=1 and dir<=up
//   - TRI: peaks are not repeated; period 2*MAX steps
//   - SQR: phase<=phase+1, wrapping like SAW
//  Output decode, a pure function of registered state (no combinational path from inputs):
//   - IDLE -> 0
//   - SAW, TRI -> phase
//   - SQR -> phase[WIDTH-1] ? MAX : 0 (50% duty, low half first, period 2**WIDTH steps)
//  Latency: the sample after a cmd_rdy edge is 0. It advances 1 on the DIV-th following enabled edge.
//  Reset mid-waveform returns to IDLE. A cmd_rdy is required to restart.
// STRUCTURE
//  Shared package wave_gen_pkg:
//   - localparam codes WT_IDLE=0, WT_SAW=1, WT_TRI=2, WT_SQR=3
//   - typedef wave_mode_t (2-bit enum)
//  Sub-module wave_gen_tick: prescaler producing a 1-cycle tick from en and DIV; cleared by cmd_rdy.
//  Top: command latch, phase/dir datapath, output decode.
// TESTING
//  - Reset: rst=1 for 1 cycle, en=1, cmd_rdy=0 -> wave_out=0, stays 0 for 50 cycles (IDLE).
//  - Sawtooth: strobe cmd_rdy with wave_type=1 -> 0,1,2..255 then 0. The 256th step after the strobe gives 0.
//  - Triangle: rst, then cmd_rdy with wave_type=2 -> 0..255 on steps 0..255; step 256 gives 254.
//    Step 510 gives 0, step 511 gives 1.
//  - Square: rst, then cmd_rdy with wave_type=3 -> 0x00 for steps 0..127, 0xFF for steps 128..255.
//    0x00 again at step 256.
//  - Enable/restart: en=0 for 20 cycles mid-sawtooth -> wave_out frozen.
//    cmd_rdy with wave_type=2 at phase 100 -> next sample 0, dir up.
//  - Illegal code and DIV: wave_type=8'h07 -> IDLE, wave_out=0.
//    With DIV=4, sawtooth advances once per 4 enabled cycles.

Source files
------------

// File: rtl/wave_gen_pkg.sv
// Shared types and codes for the wave_gen waveform source.
// Waveform mode encoding plus the command-code decoder.
package wave_gen_pkg;

  localparam logic [1:0] WT_IDLE = 2'd0;
  localparam logic [1:0] WT_SAW  = 2'd1;
  localparam logic [1:0] WT_TRI  = 2'd2;
  localparam logic [1:0] WT_SQR  = 2'd3;

  typedef enum logic [1:0] {
    M_IDLE = WT_IDLE,
    M_SAW  = WT_SAW,
    M_TRI  = WT_TRI,
    M_SQR  = WT_SQR
  } wave_mode_t;

  // Any code outside 1..3, including stray upper bits, selects IDLE
  function automatic wave_mode_t decode_wt(input logic [7:0] wt);
    wave_mode_t m;
    case (wt)
      8'd1:    m = M_SAW;
      8'd2:    m = M_TRI;
      8'd3:    m = M_SQR;
      default: m = M_IDLE;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/wave_gen_tick.sv
// Step prescaler: one-cycle tick every DIV enabled cycles.
// A command clears the count so the new waveform starts aligned.
module wave_gen_tick #(
  parameter int DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear on command, wrap at LAST, hold while disabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_o = en_i & ~clr_i & (cnt_q == LAST);

  // Count register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wave_gen.sv
// Digital waveform source: sawtooth, triangle or square samples.
// Command latch, phase/direction datapath and output decode.
module wave_gen
  import wave_gen_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cmd_rdy,
  input  logic [7:0]       wave_type,
  output logic [WIDTH-1:0] wave_out
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  wave_mode_t       mode_q, mode_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic             dir_q, dir_d;
  logic             tick;

  wave_gen_tick #(.DIV(DIV)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .clr_i  (cmd_rdy),
    .tick_o (tick)
  );

  // Next state: a command restarts from phase 0, otherwise step on tick
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    dir_d   = dir_q;
    if (cmd_rdy) begin
      mode_d  = decode_wt(wave_type);
      phase_d = '0;
      dir_d   = DIR_UP;
    end else if (tick) begin
      case (mode_q)
        M_SAW, M_SQR: phase_d = phase_q + WIDTH'(1);
        M_TRI: begin
          if (dir_q == DIR_UP) begin
            if (phase_q == MAX) begin
              phase_d = MAX - WIDTH'(1);
              dir_d   = DIR_DN;
            end else begin
              phase_d = phase_q + WIDTH'(1);
            end
          end else begin
            if (phase_q == '0) begin
              phase_d = WIDTH'(1);
              dir_d   = DIR_UP;
            end else begin
              phase_d = phase_q - WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Waveform state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= M_IDLE;
      phase_q <= '0;
      dir_q   <= DIR_UP;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      dir_q   <= dir_d;
    end
  end

  // Sample decode from registered state only
  always_comb begin
    wave_out = '0;
    case (mode_q)
      M_SAW, M_TRI: wave_out = phase_q;
      M_SQR:        wave_out = phase_q[WIDTH-1] ? MAX : '0;
      default:      wave_out = '0;
    endcase
  end

endmodule

// File: tb/tb_wave_gen.sv
// Bench for wave_gen: table vectors plus long waveform sequences.
// Checks a DIV=1 and a DIV=4 instance against a closed-form model.
module tb_wave_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       cmd_rdy = 1'b0;
  logic [7:0] wave_type = 8'd0;
  logic [7:0] out1, out4;

  always #5 clk = ~clk;

  wave_gen #(.WIDTH(8), .DIV(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cmd_rdy   (cmd_rdy),
    .wave_type (wave_type),
    .wave_out  (out1)
  );

  wave_gen #(.WIDTH(8), .DIV(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .cmd_rdy   (cmd_rdy),
    .wave_type (wave_type),
    .wave_out  (out4)
  );

  typedef struct {
    logic       r;
    logic       e;
    logic       c;
    logic [7:0] wt;
    logic [7:0] exp1;
  } vec_t;

  typedef struct {
    logic [7:0] e1;
    logic [7:0] e4;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   n_vec = 0;
  int   n_bad = 0;

  int m_mode = 0;
  int m_ecnt = 0;

  function automatic logic [7:0] wave_at(input int mode, input int k);
    int t;
    case (mode)
      1: return 8'(k % 256);
      2: begin
        t = k % 510;
        return (t <= 255) ? 8'(t) : 8'(510 - t);
      end
      3: return ((k % 256) >= 128) ? 8'hFF : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  task automatic apply(input logic r, input logic e, input logic c,
                       input logic [7:0] wt, input string tag,
                       input bit use_tab, input logic [7:0] tab_exp);
    exp_t x;
    exp_t got;
    @(negedge clk);
    rst = r; en = e; cmd_rdy = c; wave_type = wt;
    if (r) begin
      m_mode = 0; m_ecnt = 0;
    end else if (c) begin
      m_mode = (wt >= 8'd1 && wt <= 8'd3) ? int'(wt) : 0;
      m_ecnt = 0;
    end else if (e) begin
      m_ecnt++;
    end
    x.e1  = use_tab ? tab_exp : wave_at(m_mode, m_ecnt);
    x.e4  = wave_at(m_mode, m_ecnt / 4);
    x.tag = tag;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    got = sbq.pop_front();
    n_vec++;
    if (out1 !== got.e1) begin
      n_bad++;
      $display("FAIL %s div1: wave_out=%0d expected %0d", got.tag, out1, got.e1);
    end
    n_vec++;
    if (out4 !== got.e4) begin
      n_bad++;
      $display("FAIL %s div4: wave_out=%0d expected %0d", got.tag, out4, got.e4);
    end
  endtask

  task automatic run(input int n, input logic e, input string tag);
    for (int i = 0; i < n; i++) apply(1'b0, e, 1'b0, 8'd0, tag, 1'b0, 8'd0);
  endtask

  task automatic cmd(input logic [7:0] wt, input string tag);
    apply(1'b0, 1'b1, 1'b1, wt, tag, 1'b0, 8'd0);
  endtask

  task automatic reset1(input string tag);
    apply(1'b1, 1'b1, 1'b0, 8'd0, tag, 1'b0, 8'd0);
  endtask

  vec_t tab[$];

  initial begin
    tab = '{
      '{1'b1, 1'b1, 1'b0, 8'h00, 8'd0},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'd0},
      '{1'b0, 1'b1, 1'b1, 8'h01, 8'd0},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'd1},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'd2},
      '{1'b0, 1'b0, 1'b0, 8'h00, 8'd2},
      '{1'b0, 1'b0, 1'b1, 8'h03, 8'd0},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'd0},
      '{1'b0, 1'b1, 1'b1, 8'h07, 8'd0},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'd0},
      '{1'b0, 1'b1, 1'b1, 8'h82, 8'd0},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'd0},
      '{1'b0, 1'b0, 1'b1, 8'h02, 8'd0},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'd1},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'd2},
      '{1'b1, 1'b1, 1'b0, 8'h00, 8'd0},
      '{1'b0, 1'b1, 1'b0, 8'h00, 8'd0}
    };
    foreach (tab[i])
      apply(tab[i].r, tab[i].e, tab[i].c, tab[i].wt,
            $sformatf("tab%0d", i), 1'b1, tab[i].exp1);

    reset1("rst");
    run(50, 1'b1, "idle");

    cmd(8'd1, "saw_cmd");
    run(260, 1'b1, "saw");
    run(20, 1'b0, "saw_frozen");
    run(96, 1'b1, "saw_resume");
    cmd(8'd2, "restart_tri");
    run(5, 1'b1, "tri_after_restart");

    reset1("tri_rst");
    cmd(8'd2, "tri_cmd");
    run(515, 1'b1, "tri");

    reset1("sqr_rst");
    cmd(8'd3, "sqr_cmd");
    run(260, 1'b1, "sqr");

    cmd(8'h07, "illegal");
    run(10, 1'b1, "illegal_idle");

    reset1("div_rst");
    cmd(8'd1, "div_cmd");
    run(13, 1'b1, "div_saw");
    run(3, 1'b0, "div_hold");
    run(9, 1'b1, "div_saw2");

    reset1("mid_rst");
    run(10, 1'b1, "mid_rst_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
